// File: rtl/tt_um_pkg.sv
// Shared types and constants for the result drain stage.
package tt_um_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned SLOT_LEN = 8;

    localparam logic [BYTE_W-1:0] SAT_MAX = 8'h7F;
    localparam logic [BYTE_W-1:0] SAT_MIN = 8'h80;

    // One buffered frame: converted bytes, frame clip flag, occupancy bit.
    typedef struct packed {
        logic [SLOT_LEN-1:0][BYTE_W-1:0] bytes;
        logic                            sat;
        logic                            valid;
    } slot_t;

endpackage : tt_um_pkg

// File: rtl/tt_um_sat8.sv
// Converts one signed accumulator to a byte, saturating or truncating.
module tt_um_sat8
    import tt_um_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     sat_en,
    output logic        [BYTE_W-1:0] data_c,
    output logic                     clip_c
);

    if (ACC_W == 8) begin : g_pass
        // Already byte-sized: nothing can clip.
        always_comb begin
            data_c = acc;
            clip_c = 1'b0;
        end
    end else begin : g_conv
        localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(127);
        localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-128);

        logic over;
        logic under;

        // Signed range check at full accumulator width.
        always_comb begin
            over   = acc > MAX_V;
            under  = acc < MIN_V;
            data_c = acc[BYTE_W-1:0];
            clip_c = 1'b0;
            if (sat_en) begin
                if (over) begin
                    data_c = SAT_MAX;
                end else if (under) begin
                    data_c = SAT_MIN;
                end
                clip_c = over | under;
            end
        end
    end

endmodule : tt_um_sat8

// File: rtl/tt_um_result_drain.sv
// Double-buffered capture of a multiplier output vector, drained one byte per cycle.
module tt_um_result_drain
    import tt_um_pkg::*;
#(
    parameter int unsigned OUT_LEN = SLOT_LEN,
    parameter int unsigned ACC_W   = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OUT_LEN*ACC_W-1:0]   in_vec,
    input  logic                       sat_en,
    output logic [BYTE_W-1:0]          uo_data,
    output logic                       uo_valid,
    output logic                       uo_last,
    output logic                       uo_sat,
    input  logic                       uo_ready,
    output logic                       busy
);

    localparam int unsigned      IDX_W    = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_LEN - 1);

    logic [OUT_LEN-1:0][BYTE_W-1:0] conv_bytes;
    logic [OUT_LEN-1:0]             conv_clip;
    slot_t                          cap_slot;

    slot_t              act_q, act_d;
    slot_t              pend_q, pend_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]  data_d;
    logic               last_d;
    logic               sat_d;
    logic               busy_d;
    logic               fire;
    logic               retire;
    logic               cap;

    // Conversion happens on the capture path, one converter per element.
    for (genvar g = 0; g < OUT_LEN; g++) begin : g_sat
        tt_um_sat8 #(.ACC_W(ACC_W)) u_sat8 (
            .acc    (in_vec[g*ACC_W +: ACC_W]),
            .sat_en (sat_en),
            .data_c (conv_bytes[g]),
            .clip_c (conv_clip[g])
        );
    end

    // Frame record built from the converter outputs.
    always_comb begin
        cap_slot       = '0;
        cap_slot.bytes = conv_bytes;
        cap_slot.sat   = |conv_clip;
        cap_slot.valid = 1'b1;
    end

    // A slot is free for capture only while the pending buffer is empty.
    assign in_ready = ena & ~pend_q.valid;

    // Slot/index next state; output registers are fed from the next state.
    always_comb begin
        act_d  = act_q;
        pend_d = pend_q;
        idx_d  = idx_q;
        fire   = 1'b0;
        retire = 1'b0;
        cap    = 1'b0;

        if (ena) begin
            fire   = act_q.valid & uo_ready;
            retire = fire & (idx_q == IDX_LAST);
            cap    = in_valid & ~pend_q.valid;

            if (fire) begin
                idx_d = retire ? '0 : IDX_W'(idx_q + IDX_W'(1));
            end
            if (retire) begin
                act_d  = pend_q;
                pend_d = '0;
            end
            if (cap) begin
                if (!act_q.valid || retire) begin
                    act_d = cap_slot;
                end else begin
                    pend_d = cap_slot;
                end
            end
        end

        data_d = act_d.valid ? act_d.bytes[idx_d] : '0;
        last_d = act_d.valid & (idx_d == IDX_LAST);
        sat_d  = act_d.valid & act_d.sat;
        busy_d = act_d.valid | pend_d.valid;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q    <= '0;
            pend_q   <= '0;
            idx_q    <= '0;
            uo_data  <= '0;
            uo_valid <= 1'b0;
            uo_last  <= 1'b0;
            uo_sat   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            act_q    <= act_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            uo_data  <= data_d;
            uo_valid <= act_d.valid;
            uo_last  <= last_d;
            uo_sat   <= sat_d;
            busy     <= busy_d;
        end
    end

endmodule : tt_um_result_drain

// File: tb/tb_tt_um_result_drain.sv
// Directed bench for tt_um_result_drain (OUT_LEN=8, ACC_W=12).
module tb_tt_um_result_drain;

    typedef int         ivec_t [8];
    typedef logic [7:0] bvec_t [8];

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] in_vec = '0;
    logic        sat_en = 1'b0;
    logic [7:0]  uo_data;
    logic        uo_valid;
    logic        uo_last;
    logic        uo_sat;
    logic        uo_ready = 1'b1;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    ivec_t v_mix;
    ivec_t v_small;
    ivec_t v_neg;
    bvec_t e_sat;
    bvec_t e_trunc;
    bvec_t e_small;
    bvec_t e_neg;

    tt_um_result_drain #(.OUT_LEN(8), .ACC_W(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .sat_en   (sat_en),
        .uo_data  (uo_data),
        .uo_valid (uo_valid),
        .uo_last  (uo_last),
        .uo_sat   (uo_sat),
        .uo_ready (uo_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pack(input ivec_t v);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*12 +: 12] = 12'(v[i]);
        end
        return r;
    endfunction

    // Present a vector for one edge; returns at the negedge showing element 0.
    task automatic put(input ivec_t v, input logic s);
        in_vec   = pack(v);
        sat_en   = s;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Drain a frame with uo_ready high; starts at the negedge showing element 0.
    task automatic drain(input string tag, input bvec_t e, input logic exp_sat);
        for (int k = 0; k < 8; k++) begin
            chk1({tag, "_valid"}, uo_valid, 1'b1);
            chk8({tag, "_data"}, uo_data, e[k]);
            chk1({tag, "_last"}, uo_last, k == 7);
            if (k == 7) chk1({tag, "_sat"}, uo_sat, exp_sat);
            @(negedge clk);
        end
    endtask

    initial begin
        v_mix   = '{5, -3, 200, -300, 127, -128, 0, 2047};
        v_small = '{1, 2, 3, 4, 5, 6, 7, 8};
        v_neg   = '{-1, -2, -3, -4, -5, -6, -7, -8};
        e_sat   = '{8'h05, 8'hFD, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h00, 8'h7F};
        e_trunc = '{8'h05, 8'hFD, 8'hC8, 8'hD4, 8'h7F, 8'h80, 8'h00, 8'hFF};
        e_small = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        e_neg   = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk1("rst_valid", uo_valid, 1'b0);
        chk1("rst_last", uo_last, 1'b0);
        chk1("rst_sat", uo_sat, 1'b0);
        chk8("rst_data", uo_data, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Saturation
        put(v_mix, 1'b1);
        drain("sat", e_sat, 1'b1);
        chk1("sat_idle_valid", uo_valid, 1'b0);
        chk8("sat_idle_data", uo_data, 8'h00);
        chk1("sat_idle_busy", busy, 1'b0);

        // Truncation
        put(v_mix, 1'b0);
        drain("trunc", e_trunc, 1'b0);
        chk1("trunc_idle_valid", uo_valid, 1'b0);

        // Back-pressure: ready pattern 1,0,0,1 repeating
        put(v_mix, 1'b1);
        begin
            int k;
            k = 0;
            for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
                chk1("bp_valid", uo_valid, 1'b1);
                chk8("bp_data", uo_data, e_sat[k]);
                chk1("bp_last", uo_last, k == 7);
                uo_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                @(negedge clk);
                if (uo_ready) k++;
            end
            uo_ready = 1'b1;
            chk8("bp_count", 8'(k), 8'd8);
            chk1("bp_idle_valid", uo_valid, 1'b0);
        end

        // Double buffer: A, then B next cycle, C held until a slot frees
        in_vec   = pack(v_mix);
        sat_en   = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk8("db_a0", uo_data, e_sat[0]);
        chk1("db_ready_a", in_ready, 1'b1);
        in_vec = pack(v_small);
        @(negedge clk);
        chk8("db_a1", uo_data, e_sat[1]);
        chk1("db_ready_b", in_ready, 1'b0);
        chk1("db_busy", busy, 1'b1);
        in_vec = pack(v_neg);
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            chk8("db_a", uo_data, e_sat[k]);
            chk1("db_c_refused", in_ready, 1'b0);
        end
        chk1("db_a_last", uo_last, 1'b1);
        chk1("db_a_sat", uo_sat, 1'b1);
        @(negedge clk);
        chk1("db_b0_valid", uo_valid, 1'b1);
        chk8("db_b0", uo_data, e_small[0]);
        chk1("db_b0_last", uo_last, 1'b0);
        chk1("db_ready_c", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk8("db_b1", uo_data, e_small[1]);
        chk1("db_c_taken", in_ready, 1'b0);
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            chk8("db_b", uo_data, e_small[k]);
        end
        chk1("db_b_last", uo_last, 1'b1);
        chk1("db_b_sat", uo_sat, 1'b0);
        @(negedge clk);
        drain("db_c", e_neg, 1'b0);
        chk1("db_idle_valid", uo_valid, 1'b0);
        chk1("db_idle_busy", busy, 1'b0);

        // ena freeze for 5 cycles at element 2
        put(v_small, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk8("frz_pre", uo_data, e_small[2]);
        ena = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk8("frz_data", uo_data, e_small[2]);
            chk1("frz_valid", uo_valid, 1'b1);
            chk1("frz_in_ready", in_ready, 1'b0);
        end
        ena = 1'b1;
        @(negedge clk);
        for (int k = 3; k < 8; k++) begin
            chk8("frz_resume", uo_data, e_small[k]);
            chk1("frz_last", uo_last, k == 7);
            @(negedge clk);
        end
        chk1("frz_idle_valid", uo_valid, 1'b0);

        // Async reset during element 3
        put(v_mix, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk8("ar_e3", uo_data, e_sat[3]);
        #2 rst_n = 1'b0;
        #1;
        chk1("ar_valid", uo_valid, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        chk1("ar_in_ready", in_ready, 1'b1);
        chk8("ar_data", uo_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("ar_post_valid", uo_valid, 1'b0);
        put(v_mix, 1'b0);
        drain("ar_restart", e_trunc, 1'b0);
        chk1("ar_idle_valid", uo_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tt_um_result_drain
